booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//  Parametrised sequential radix-4 Booth multiplier: one Booth digit per clock, partial products accumulated in-place.
//  Successor to the fixed 16-bit Booth/Wallace multiplier: adds generic width, signed/unsigned mode,
//  a start/busy/done handshake and optional early termination. Sits as an arithmetic leaf under the datapath controller.
// PARAMETERS
//  N      16  operand width; must be even and >= 4 (elaboration error otherwise)
//  CNT_W  $clog2(N/2+2)  digit-counter width (derived; do not override)
// PORTS
//  clk          in   1     system clock; all state updates on rising edge
//  reset        in   1     synchronous, active-high reset
//  start        in   1     request; accepted only when busy==0
//  signed_mode  in   1     1: md/mr two's complement; 0: unsigned
//  md           in   N     multiplicand
//  mr           in   N     multiplier
//  busy         out  1     high while digits are being processed (RUN)
//  done         out  1     one-cycle pulse: product valid
//  product      out  2N    result; held stable until the next accepted start
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, busy=0, done=0, product=0, accumulator/counter=0; overrides any operation in flight.
//  - States: IDLE -> RUN on start; RUN -> DONE after last digit; DONE -> RUN on start (back-to-back), else -> IDLE.
//  - Accept edge: latch md, mr, signed_mode; acc=0; cnt=0. md extended to N+2 bits (sign- or zero-extended).
//  - mr extended to N+3 bits {ext,ext,mr,1'b0}, where ext = signed_mode ? mr[N-1] : 0.
//  - Digit count D = N/2 (signed) or N/2+1 (unsigned); window i = bits [2i+2:2i] of the extended mr.
//  - Encode: 000,111->0; 001,010->+1; 011->+2; 100->-2; 101,110->-1.
//    Negation is ~x+1, formed in 2N-bit two's complement before the add.
//  - Each RUN edge: acc += sext_2N(pp_i) << 2*cnt; cnt++. acc is 2N bits, wrap-around discarded (exact for all inputs).
//  - Last digit edge: product<=acc result, done=1 for exactly one cycle, state=DONE, busy=0.
//  - Latency: start sampled at edge k -> done high after edge k+D (16-bit: 8 signed, 9 unsigned).
//  - start while busy=1: ignored, no effect on operands or state. start in DONE: accepted, done drops next cycle.
//  - product changes only at the done edge; reads between operations return the previous result.
// CONFIGURATION
//  BOOTH_EARLY_TERM_EN defined: after each digit, if all remaining extended-mr bits (including the overlap bit)
//    are equal, the remaining digits are all 0, so RUN ends at that edge. Latency is 1..D cycles and depends on data.
//    Minimum is 1 digit.
//  Undefined: latency is always exactly D. product values are identical in both builds.
// STRUCTURE
//  booth_pkg: state enum (IDLE/RUN/DONE), digit-encoding localparams (ZERO, P1, P2, M1, M2), helper function for D(N, mode).
//  Sub-module booth_pp_gen (combinational): 3-bit window + extended md -> signed N+2-bit partial product.
//    This is the encoder/decoder pair; it is also the unit targeted by the low-power work.
//  Top: FSM, counter, shift of mr, accumulator, output registers.
// TESTING (N=16 unless noted)
//  1 signed 3 * -5 -> product 0xFFFF_FFF1, done 8 cycles after start edge, busy high 8 cycles
//  2 signed 0x8000*0x8000 -> 0x4000_0000; unsigned 0xFFFF*0xFFFF -> 0xFFFE_0001, latency 9
//  3 start pulsed every cycle during RUN -> single result, latency unchanged; start in DONE -> next op, no idle gap
//  4 reset asserted mid-RUN -> next cycle busy=0, done=0, product=0; no stray done afterwards
//  5 BOOTH_EARLY_TERM_EN: signed mr=1, md=7 -> 7 after 1 cycle; mr=0 -> 0 after 1 cycle; undefined -> 8 cycles each
//  6 N=8 and N=32: 2000 random signed/unsigned pairs vs reference model; product must match; latency = D (or <= D with macro)

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared types and constants for the sequential radix-4 Booth multiplier.
//   state_t      controller states (IDLE / RUN / DONE)
//   ZERO..M2     internal Booth digit codes used between encoder and decoder
//   num_digits   number of radix-4 digits processed for an N-bit operand
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] ZERO = 3'd0;
    localparam logic [2:0] P1   = 3'd1;
    localparam logic [2:0] P2   = 3'd2;
    localparam logic [2:0] M1   = 3'd3;
    localparam logic [2:0] M2   = 3'd4;

    // Unsigned operands need one extra digit to consume the zero extension bits.
    function automatic int unsigned num_digits(input int unsigned n, input logic is_signed);
        return is_signed ? (n / 2) : (n / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen
//   Combinational radix-4 Booth encoder/decoder: one 3-bit multiplier window
//   selects 0, +-md or +-2*md.
// Ports
//   window  in   3      multiplier bits [2i+2:2i] (bit 0 is the overlap bit)
//   md_ext  in   N+2    multiplicand, already sign- or zero-extended
//   pp      out  N+2    signed partial product (two's complement)
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [2:0]   window,
    input  logic [N+1:0] md_ext,
    output logic [N+1:0] pp
);

    logic [2:0]   digit;
    logic [N+1:0] mag;

    always_comb begin
        digit = ZERO;
        case (window)
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
    end

    // N+2 bits hold every value of +-2*md exactly, so negating here and
    // sign-extending afterwards gives the same bits as negating at 2N width.
    always_comb begin
        mag = '0;
        case (digit)
            P1, M1:  mag = md_ext;
            P2, M2:  mag = {md_ext[N:0], 1'b0};
            default: mag = '0;
        endcase
        pp = ((digit == M1) || (digit == M2)) ? (~mag + (N+2)'(1)) : mag;
    end

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Sequential radix-4 Booth multiplier, one Booth digit per clock, partial
//   products accumulated in place into a 2N-bit accumulator.
// Ports
//   clk          in   1    system clock
//   reset        in   1    synchronous, active-high reset
//   start        in   1    request, accepted when not busy
//   signed_mode  in   1    1: two's complement operands, 0: unsigned
//   md           in   N    multiplicand
//   mr           in   N    multiplier
//   busy         out  1    high while digits are processed
//   done         out  1    one-cycle pulse, product valid
//   product      out  2N   result, held until the next completed operation
// Build option
//   BOOTH_EARLY_TERM_EN  stop RUN as soon as all remaining multiplier digits are 0
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = $clog2(N/2+2)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   md,
    input  logic [N-1:0]   mr,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    if ((N % 2) != 0 || N < 4) begin : g_bad_n
        $error("booth_mult_seq: N must be even and >= 4");
    end

    state_t           state;
    logic [N+1:0]     md_r;
    logic [N+2:0]     mr_sh;
    logic [2*N-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last;
    logic [N+1:0]     pp;
    logic [2*N-1:0]   pp_ext;
    logic [2*N-1:0]   acc_next;
    logic             mr_ext;
    logic             last_digit;

    booth_pp_gen #(.N(N)) u_pp_gen (
        .window (mr_sh[2:0]),
        .md_ext (md_r),
        .pp     (pp)
    );

    assign mr_ext   = signed_mode & mr[N-1];
    assign pp_ext   = {{(N-2){pp[N+1]}}, pp};
    assign acc_next = acc + (pp_ext << {cnt, 1'b0});

    // mr_sh shifts right arithmetically, so bits [N+2:2] are exactly the
    // remaining extended-mr bits (overlap bit included) padded with copies of
    // the top bit; if they are all equal every remaining window is 000 or 111.
`ifdef BOOTH_EARLY_TERM_EN
    assign last_digit = (cnt == cnt_last) || (&mr_sh[N+2:2]) || (~|mr_sh[N+2:2]);
`else
    assign last_digit = (cnt == cnt_last);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            acc      <= '0;
            cnt      <= '0;
            cnt_last <= '0;
            md_r     <= '0;
            mr_sh    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        md_r     <= signed_mode ? {{2{md[N-1]}}, md} : {2'b00, md};
                        mr_sh    <= {{2{mr_ext}}, mr, 1'b0};
                        acc      <= '0;
                        cnt      <= '0;
                        cnt_last <= CNT_W'(num_digits(N, signed_mode) - 1);
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    cnt   <= cnt + CNT_W'(1);
                    mr_sh <= {{2{mr_sh[N+2]}}, mr_sh[N+2:2]};
                    if (last_digit) begin
                        product <= acc_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

    logic clk;
    logic reset;

    logic        start8,  sm8,  busy8,  done8;
    logic [7:0]  md8,  mr8;
    logic [15:0] prod8;
    logic        start16, sm16, busy16, done16;
    logic [15:0] md16, mr16;
    logic [31:0] prod16;
    logic        start32, sm32, busy32, done32;
    logic [31:0] md32, mr32;
    logic [63:0] prod32;

    int n_vec = 0;
    int n_err = 0;

    booth_mult_seq #(.N(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
        .md(md8), .mr(mr8), .busy(busy8), .done(done8), .product(prod8));
    booth_mult_seq #(.N(16)) u16 (
        .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16),
        .md(md16), .mr(mr16), .busy(busy16), .done(done16), .product(prod16));
    booth_mult_seq #(.N(32)) u32 (
        .clk(clk), .reset(reset), .start(start32), .signed_mode(sm32),
        .md(md32), .mr(mr32), .busy(busy32), .done(done32), .product(prod32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: true mathematical product truncated to 2w bits.
    function automatic longint unsigned ref_prod(input int w, input bit sm,
                                                 input longint unsigned a, input longint unsigned b);
        longint unsigned wm, m, ua, ub;
        longint sa, sb;
        wm = (64'd1 << w) - 64'd1;
        m  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
        ua = a & wm;
        ub = b & wm;
        if (sm) begin
            sa = ua[w-1] ? longint'(ua | ~wm) : longint'(ua);
            sb = ub[w-1] ? longint'(ub | ~wm) : longint'(ub);
            return longint'(sa * sb) & m;
        end
        return (ua * ub) & m;
    endfunction

    // Reference latency: D digits, or with early termination the first digit
    // count k after which all extended-mr bits from 2k upward are equal.
    function automatic int ref_lat(input int w, input bit sm, input longint unsigned b);
        int  d;
        bit  [66:0] x;
        bit  e;
        bit  same;
        d = sm ? w/2 : w/2 + 1;
        e = sm & b[w-1];
        x = '0;
        for (int j = 0; j < w; j++) x[j+1] = b[j];
        x[w+1] = e;
        x[w+2] = e;
`ifdef BOOTH_EARLY_TERM_EN
        for (int k = 1; k < d; k++) begin
            same = 1'b1;
            for (int j = 2*k; j <= w+2; j++) if (x[j] != x[2*k]) same = 1'b0;
            if (same) return k;
        end
`else
        same = x[0];
`endif
        return d;
    endfunction

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input bit sm, input longint unsigned a, input longint unsigned b);
        case (w)
            8:       begin sm8  = sm; md8  = a[7:0];  mr8  = b[7:0];  end
            16:      begin sm16 = sm; md16 = a[15:0]; mr16 = b[15:0]; end
            default: begin sm32 = sm; md32 = a[31:0]; mr32 = b[31:0]; end
        endcase
    endtask

    task automatic set_start(input int w, input bit v);
        case (w)
            8:       start8  = v;
            16:      start16 = v;
            default: start32 = v;
        endcase
    endtask

    task automatic sample(input int w, output bit d, output bit bz, output longint unsigned p);
        case (w)
            8:       begin d = done8;  bz = busy8;  p = 64'(prod8);  end
            16:      begin d = done16; bz = busy16; p = 64'(prod16); end
            default: begin d = done32; bz = busy32; p = prod32;      end
        endcase
    endtask

    // Called at the negedge right after the accept edge.
    task automatic wait_done(input int w, input longint unsigned exp_p, input int exp_l, input string tag);
        int lat, busy_n;
        bit d, bz, seen;
        longint unsigned p;
        lat = 0; busy_n = 0; seen = 1'b0;
        while (1) begin
            sample(w, d, bz, p);
            if (d) begin seen = 1'b1; break; end
            if (bz) busy_n++;
            if (lat >= 40) break;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_product"}, p, exp_p);
            chk({tag, "_latency"}, 64'(lat), 64'(exp_l));
            chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_l));
            chk({tag, "_busy_at_done"}, 64'(bz), 64'd0);
        end
    endtask

    task automatic do_op(input int w, input bit sm, input longint unsigned a, input longint unsigned b,
                         input string tag);
        bit d, bz;
        longint unsigned p, exp_p;
        exp_p = ref_prod(w, sm, a, b);
        @(negedge clk);
        set_in(w, sm, a, b);
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        wait_done(w, exp_p, ref_lat(w, sm, b), tag);
        @(negedge clk);
        sample(w, d, bz, p);
        chk({tag, "_done_pulse"}, 64'(d), 64'd0);
        chk({tag, "_held"}, p, exp_p);
    endtask

    initial begin
        bit d, bz, seen;
        longint unsigned p, exp_a, exp_c;
        int lat, exp_l, n_done;

        reset = 1'b1;
        start8 = 0; sm8 = 0; md8 = '0; mr8 = '0;
        start16 = 0; sm16 = 0; md16 = '0; mr16 = '0;
        start32 = 0; sm32 = 0; md32 = '0; mr32 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy16", 64'(busy16), 64'd0);
        chk("rst_done16", 64'(done16), 64'd0);
        chk("rst_prod16", 64'(prod16), 64'd0);
        chk("rst_prod8",  64'(prod8),  64'd0);
        chk("rst_prod32", prod32,      64'd0);
        reset = 1'b0;

        // signed 3 * -5
        do_op(16, 1'b1, 64'd3, 64'hFFFB, "s3xm5");
        chk("s3xm5_const", 64'(prod16), 64'hFFFF_FFF1);
        do_op(16, 1'b1, 64'h8000, 64'h8000, "smin_sq");
        chk("smin_sq_const", 64'(prod16), 64'h4000_0000);
        do_op(16, 1'b0, 64'hFFFF, 64'hFFFF, "umax_sq");
        chk("umax_sq_const", 64'(prod16), 64'hFFFE_0001);
        do_op(16, 1'b1, 64'd7, 64'd1, "mr_one");
        do_op(16, 1'b1, 64'h1234, 64'd0, "mr_zero");
        do_op(16, 1'b1, 64'h7FFF, 64'hFFFF, "mr_m1");
        do_op(16, 1'b0, 64'h8000, 64'h0001, "u_mr_one");

        // start held high through RUN with scrambled operands, then start in DONE
        exp_a = ref_prod(16, 1'b1, 64'h1234, 64'h8765);
        exp_l = ref_lat(16, 1'b1, 64'h8765);
        exp_c = ref_prod(16, 1'b0, 64'hABCD, 64'h00FF);
        @(negedge clk);
        set_in(16, 1'b1, 64'h1234, 64'h8765);
        start16 = 1'b1;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            sample(16, d, bz, p);
            if (d) seen = 1'b1;
            else begin
                lat++;
                set_in(16, 1'($urandom_range(1)), 64'($urandom), 64'($urandom));
            end
        end
        chk("hold_done_seen", 64'(seen), 64'd1);
        chk("hold_product", p, exp_a);
        chk("hold_latency", 64'(lat), 64'(exp_l));
        set_in(16, 1'b0, 64'hABCD, 64'h00FF);
        @(negedge clk);
        start16 = 1'b0;
        chk("b2b_no_gap_busy", 64'(busy16), 64'd1);
        chk("b2b_prev_held", 64'(prod16), exp_a);
        wait_done(16, exp_c, ref_lat(16, 1'b0, 64'h00FF), "b2b");

        // reset in the middle of RUN
        @(negedge clk);
        set_in(16, 1'b1, 64'h5A5A, 64'h9999);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(busy16), 64'd0);
        chk("midrst_done", 64'(done16), 64'd0);
        chk("midrst_prod", 64'(prod16), 64'd0);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done16) n_done++;
        end
        chk("midrst_no_stray_done", 64'(n_done), 64'd0);
        do_op(16, 1'b1, 64'hFFFD, 64'h0005, "after_rst");

        // random operands on the 8- and 32-bit instances
        for (int i = 0; i < 1000; i++)
            do_op(8, 1'($urandom_range(1)), 64'($urandom), 64'($urandom), "rnd8");
        do_op(8, 1'b1, 64'h80, 64'h80, "n8_smin");
        do_op(8, 1'b0, 64'hFF, 64'hFF, "n8_umax");
        for (int i = 0; i < 1000; i++)
            do_op(32, 1'($urandom_range(1)), 64'($urandom), 64'($urandom), "rnd32");
        do_op(32, 1'b1, 64'h8000_0000, 64'h8000_0000, "n32_smin");
        do_op(32, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "n32_umax");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
